// File: rtl/spi_pkg.sv
// ----------------------------------------------------------------------------
// spi_pkg
// Shared types and helpers for the parametrised SPI master.
//   state_t    : transfer sequencer states (IDLE, LEAD, XFER, TRAIL)
//   MODE0..3   : SPI modes encoded as {CKP, CPH}
//   cnt_width  : width of a counter that must hold the value n
// ----------------------------------------------------------------------------
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    XFER  = 2'd2,
    TRAIL = 2'd3
  } state_t;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// ----------------------------------------------------------------------------
// spi_sck_gen
// SCK timebase for the SPI master. A divider produces a tick every CLK_DIV
// clk cycles while 'run' is high; every tick with 'toggle_en' high is one SCK
// edge, numbered 1..EDGES.
// Ports:
//   clk, rst    : system clock, asynchronous active-high reset
//   run         : divider runs (any non-idle state); low clears everything
//   toggle_en   : ticks produce SCK edges (the tick ending LEAD is edge 1)
//   tick        : divider terminal count, one clk cycle wide
//   phase       : SCK relative to its idle level (0 = idle)
//   edge_num    : number of the edge occurring on this tick
//   lead_edge   : odd-numbered edge happening now
//   trail_edge  : even-numbered edge happening now
//   last_edge   : edge_num equals EDGES
// ----------------------------------------------------------------------------
module spi_sck_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int EDGES   = 32,
  parameter int EW      = cnt_width(EDGES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          toggle_en,
  output logic          tick,
  output logic          phase,
  output logic [EW-1:0] edge_num,
  output logic          lead_edge,
  output logic          trail_edge,
  output logic          last_edge
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic [EW-1:0]    edge_cnt;
  logic             edge_now;

  assign tick       = run && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign edge_now   = tick && toggle_en;
  assign edge_num   = edge_cnt + EW'(1);
  assign lead_edge  = edge_now && edge_num[0];
  assign trail_edge = edge_now && !edge_num[0];
  assign last_edge  = (edge_num == EW'(EDGES));

  // Divider and edge bookkeeping restart from zero whenever the master idles,
  // so every transfer sees identical SCK timing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt  <= '0;
      edge_cnt <= '0;
      phase    <= 1'b0;
    end else if (!run) begin
      div_cnt  <= '0;
      edge_cnt <= '0;
      phase    <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
      if (edge_now) begin
        edge_cnt <= edge_num;
        phase    <= ~phase;
      end
    end
  end

endmodule

// File: rtl/spi_master_param.sv
// ----------------------------------------------------------------------------
// spi_master_param
// Parametrised SPI master: shifts data_in out on MOSI while capturing MISO,
// all four CKP/CPH modes, NUM_CS active-low chip selects, start/busy/done
// handshake.
// Optional feature: define SPI_MASTER_LSB_FIRST_EN to add the 'lsb_first'
// input (latched at start, 1 = LSB first). Without it, MSB first is fixed.
// Ports:
//   clk, rst        : system clock, asynchronous active-high reset
//   strt            : start request, honoured only while idle
//   CKP, CPH        : SCK idle level / sample-on-trailing-edge, latched at start
//   cs_sel          : target slave, latched at start (out of range = no CS)
//   lsb_first       : (optional) bit order, latched at start
//   data_in         : word to transmit, latched at start
//   MISO            : serial data from slave
//   MOSI, SCK, CS   : serial data out, serial clock, active-low selects
//   busy            : transfer in progress
//   done            : one-cycle pulse when rx_data is updated
//   rx_data         : last received word
// ----------------------------------------------------------------------------
module spi_master_param
  import spi_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 2,
  parameter int NUM_CS  = 2,
  localparam int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              strt,
  input  logic              CKP,
  input  logic              CPH,
  input  logic [CS_W-1:0]   cs_sel,
`ifdef SPI_MASTER_LSB_FIRST_EN
  input  logic              lsb_first,
`endif
  input  logic [DATA_W-1:0] data_in,
  input  logic              MISO,
  output logic              MOSI,
  output logic              SCK,
  output logic [NUM_CS-1:0] CS,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data
);

  localparam int EDGES = 2 * DATA_W;
  localparam int EW    = cnt_width(EDGES);
  localparam int BIT_W = cnt_width(DATA_W);

  state_t            state, state_next;
  logic [1:0]        mode_l;
  logic [CS_W-1:0]   cs_l;
  logic [DATA_W-1:0] tx_word;
  logic [DATA_W-1:0] rx_sr;
  logic [DATA_W-1:0] rx_q;
  logic [BIT_W-1:0]  bit_cnt, bit_cnt_next;
  logic              mosi_q, done_q;
  logic              lsb_l, lsb_start;

  logic              run, toggle_en, tick, phase;
  logic [EW-1:0]     edge_num, tx_idx, tx_pos;
  logic              lead_edge, trail_edge, last_edge;
  logic              cph_mode, sample, shift, xfer_end, start, next_bit;

`ifdef SPI_MASTER_LSB_FIRST_EN
  assign lsb_start = lsb_first;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      lsb_l <= 1'b0;
    else if (start)
      lsb_l <= lsb_first;
  end
`else
  assign lsb_start = 1'b0;
  assign lsb_l     = 1'b0;
`endif

  assign start     = (state == IDLE) && strt;
  assign run       = (state != IDLE);
  assign toggle_en = (state == LEAD) || (state == XFER);

  spi_sck_gen #(
    .CLK_DIV (CLK_DIV),
    .EDGES   (EDGES),
    .EW      (EW)
  ) u_sck_gen (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .toggle_en  (toggle_en),
    .tick       (tick),
    .phase      (phase),
    .edge_num   (edge_num),
    .lead_edge  (lead_edge),
    .trail_edge (trail_edge),
    .last_edge  (last_edge)
  );

  // Edge roles. Edge k shifts out bit k/2 in both phases: even edges for
  // CPH=0 (never the final edge), odd edges for CPH=1 (edge 1 re-presents
  // the bit already driven in LEAD).
  always_comb begin
    cph_mode     = mode_l inside {MODE1, MODE3};
    sample       = cph_mode ? trail_edge : lead_edge;
    shift        = cph_mode ? lead_edge : (trail_edge && !last_edge);
    bit_cnt_next = sample ? bit_cnt + BIT_W'(1) : bit_cnt;
    xfer_end     = tick && last_edge && (bit_cnt_next == BIT_W'(DATA_W));
    tx_idx       = edge_num >> 1;
    tx_pos       = lsb_l ? tx_idx : EW'(DATA_W - 1) - tx_idx;
    next_bit     = |(tx_word & (DATA_W'(1) << tx_pos));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (strt)     state_next = LEAD;
      LEAD:    if (tick)     state_next = XFER;
      XFER:    if (xfer_end) state_next = TRAIL;
      TRAIL:   if (tick)     state_next = IDLE;
      default:               state_next = IDLE;
    endcase
  end

  // Shift registers, latched configuration and the done/rx_data handoff.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_l  <= MODE0;
      cs_l    <= '0;
      tx_word <= '0;
      rx_sr   <= '0;
      rx_q    <= '0;
      bit_cnt <= '0;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        mode_l  <= {CKP, CPH};
        cs_l    <= cs_sel;
        tx_word <= data_in;
        bit_cnt <= '0;
        mosi_q  <= lsb_start ? data_in[0] : data_in[DATA_W-1];
      end else begin
        if (sample) begin
          rx_sr   <= lsb_l ? {MISO, rx_sr[DATA_W-1:1]}
                           : {rx_sr[DATA_W-2:0], MISO};
          bit_cnt <= bit_cnt_next;
        end
        if (shift)
          mosi_q <= next_bit;
        if ((state == TRAIL) && tick) begin
          rx_q   <= rx_sr;
          done_q <= 1'b1;
        end
      end
    end
  end

  // Chip selects decode straight from state so reset releases them at once.
  always_comb begin
    CS = '1;
    if (state != IDLE) begin
      for (int i = 0; i < NUM_CS; i++) begin
        if (int'(cs_l) == i)
          CS[i] = 1'b0;
      end
    end
  end

  assign SCK     = mode_l[1] ^ phase;
  assign MOSI    = mosi_q;
  assign busy    = (state != IDLE);
  assign done    = done_q;
  assign rx_data = rx_q;

endmodule

// File: tb/tb_spi_master_param.sv
// ----------------------------------------------------------------------------
// tb_spi_master_param
// Directed bench for spi_master_param. dut0 uses default parameters with a
// loopback / constant MISO; dut1 (DATA_W=8, CLK_DIV=1, NUM_CS=3) talks to a
// small mode-1 slave model. Define SPI_MASTER_LSB_FIRST_EN to add the
// LSB-first case.
// ----------------------------------------------------------------------------
module tb_spi_master_param;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;

  // Free-running cycle number, read at negedges to time events
  always @(posedge clk) cyc <= cyc + 1;

  // dut0: defaults
  logic        strt0, ckp0, cph0, sel0, lsb0, miso0, mosi0, sck0, busy0, done0;
  logic        loop0, mconst0;
  logic [15:0] din0, rx0;
  logic [1:0]  cs0;

  assign miso0 = loop0 ? mosi0 : mconst0;

  spi_master_param u_dut0 (
    .clk       (clk),
    .rst       (rst),
    .strt      (strt0),
    .CKP       (ckp0),
    .CPH       (cph0),
    .cs_sel    (sel0),
`ifdef SPI_MASTER_LSB_FIRST_EN
    .lsb_first (lsb0),
`endif
    .data_in   (din0),
    .MISO      (miso0),
    .MOSI      (mosi0),
    .SCK       (sck0),
    .CS        (cs0),
    .busy      (busy0),
    .done      (done0),
    .rx_data   (rx0)
  );

  // dut1: 8-bit, fastest SCK, three selects
  logic       strt1, ckp1, cph1, lsb1, miso1, mosi1, sck1, busy1, done1;
  logic [1:0] sel1;
  logic [7:0] din1, rx1;
  logic [2:0] cs1;

  spi_master_param #(
    .DATA_W  (8),
    .CLK_DIV (1),
    .NUM_CS  (3)
  ) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .strt      (strt1),
    .CKP       (ckp1),
    .CPH       (cph1),
    .cs_sel    (sel1),
`ifdef SPI_MASTER_LSB_FIRST_EN
    .lsb_first (lsb1),
`endif
    .data_in   (din1),
    .MISO      (miso1),
    .MOSI      (mosi1),
    .SCK       (sck1),
    .CS        (cs1),
    .busy      (busy1),
    .done      (done1),
    .rx_data   (rx1)
  );

  // Mode-1 slave: presents the next bit on SCK rising, captures MOSI on falling
  logic [7:0] slave_word;
  logic [7:0] slave_tmp;
  logic [7:0] slave_rx;
  logic       slave_rst;
  int         slave_cnt;

  always @(posedge sck1 or posedge slave_rst) begin
    if (slave_rst) slave_cnt <= 0;
    else           slave_cnt <= slave_cnt + 1;
  end

  always @(negedge sck1 or posedge slave_rst) begin
    if (slave_rst) slave_rx <= 8'h00;
    else           slave_rx <= {slave_rx[6:0], mosi1};
  end

  always_comb begin
    miso1     = 1'b0;
    slave_tmp = 8'h00;
    if (slave_cnt >= 1 && slave_cnt <= 8) begin
      slave_tmp = slave_word >> (8 - slave_cnt);
      miso1     = slave_tmp[0];
    end
  end

  // Observations collected by the stimulus tasks
  int   checks = 0;
  int   passes = 0;
  int   t0, done_at, done_cnt, cs_bad, sck_edges, first_edge, mosi_high;
  logic busy_first, busy_end, sck_lead, sck_end, mosi_first, prev_sck;
  logic rst_sck, rst_busy;
  logic [1:0] rst_cs;

  task automatic checkOutput(input string tag, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // One dut0 transfer started in cycle 0, observed for 90 cycles.
  // pulse_at re-asserts strt in that cycle; rst_at asserts reset there.
  task automatic applyStimulus(input logic ckp, input logic cph, input logic sel,
                               input logic lsb, input logic [15:0] d,
                               input int pulse_at, input int rst_at);
    logic [1:0] exp_cs;
    @(negedge clk);
    ckp0 = ckp; cph0 = cph; sel0 = sel; lsb0 = lsb; din0 = d; strt0 = 1'b1;
    t0 = cyc;
    done_at = -1; done_cnt = 0; cs_bad = 0; sck_edges = 0; first_edge = -1;
    mosi_high = 0;
    for (int r = 1; r <= 90; r++) begin
      @(negedge clk);
      strt0 = (r == pulse_at);
      if (rst_at > 0 && r == rst_at + 1) rst = 1'b0;
      if (cyc - t0 != r) $display("[TB] cycle bookkeeping drift at %0d", r);
      if (done0) begin
        done_cnt++;
        if (done_at < 0) done_at = r;
      end
      exp_cs = (r <= 66) ? (sel ? 2'b01 : 2'b10) : 2'b11;
      if (rst_at == 0 && cs0 !== exp_cs) cs_bad++;
      if (r == 1) begin
        busy_first = busy0; sck_lead = sck0; mosi_first = mosi0;
      end else if (r <= 67 && sck0 !== prev_sck) begin
        sck_edges++;
        if (first_edge < 0) first_edge = r;
      end
      prev_sck = sck0;
      if (r <= 66 && mosi0 === 1'b1) mosi_high++;
      if (r == 67) begin
        busy_end = busy0; sck_end = sck0;
      end
      if (r == rst_at) begin
        rst = 1'b1;
        #1;
        rst_cs = cs0; rst_sck = sck0; rst_busy = busy0;
      end
    end
  endtask

  // One dut1 transfer in mode 1 against the slave model
  task automatic applyStimulus8(input logic [1:0] sel, input logic [7:0] d);
    logic [2:0] exp_cs;
    @(negedge clk);
    slave_rst = 1'b1;
    ckp1 = 1'b0; cph1 = 1'b1; sel1 = sel; din1 = d; strt1 = 1'b1;
    t0 = cyc;
    done_at = -1; done_cnt = 0; cs_bad = 0;
    for (int r = 1; r <= 30; r++) begin
      @(negedge clk);
      strt1 = 1'b0;
      slave_rst = 1'b0;
      if (done1) begin
        done_cnt++;
        if (done_at < 0) done_at = r;
      end
      exp_cs = (r <= 17 && sel < 2'd3) ? ~(3'b001 << sel) : 3'b111;
      if (cs1 !== exp_cs) cs_bad++;
    end
  endtask

  initial begin
    rst = 1'b1;
    strt0 = 1'b0; ckp0 = 1'b0; cph0 = 1'b0; sel0 = 1'b0; lsb0 = 1'b0;
    din0 = 16'h0000; loop0 = 1'b1; mconst0 = 1'b0;
    strt1 = 1'b0; ckp1 = 1'b0; cph1 = 1'b0; sel1 = 2'd0; lsb1 = 1'b0;
    din1 = 8'h00; slave_word = 8'h3C; slave_rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_sck", {31'd0, sck0}, 32'd0);
    checkOutput("reset_mosi", {31'd0, mosi0}, 32'd0);
    checkOutput("reset_cs", {30'd0, cs0}, 32'd3);
    checkOutput("reset_busy", {31'd0, busy0}, 32'd0);
    checkOutput("reset_done", {31'd0, done0}, 32'd0);
    checkOutput("reset_rx", {16'd0, rx0}, 32'd0);
    rst = 1'b0;
    slave_rst = 1'b0;

    // Mode 0 loopback
    loop0 = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'hA5C3, 0, 0);
    checkOutput("m0_rx", {16'd0, rx0}, 32'h0000A5C3);
    checkOutput("m0_done_at", done_at, 67);
    checkOutput("m0_done_cnt", done_cnt, 1);
    checkOutput("m0_cs_bad", cs_bad, 0);
    checkOutput("m0_sck_edges", sck_edges, 32);
    checkOutput("m0_first_edge", first_edge, 3);
    checkOutput("m0_busy_first", {31'd0, busy_first}, 32'd1);
    checkOutput("m0_busy_end", {31'd0, busy_end}, 32'd0);

    // Mode 3, second slave, MISO stuck high
    loop0 = 1'b0; mconst0 = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'h0001, 0, 0);
    checkOutput("m3_rx", {16'd0, rx0}, 32'h0000FFFF);
    checkOutput("m3_done_at", done_at, 67);
    checkOutput("m3_cs_bad", cs_bad, 0);
    checkOutput("m3_sck_lead", {31'd0, sck_lead}, 32'd1);
    checkOutput("m3_sck_end", {31'd0, sck_end}, 32'd1);

    // Mode 2 loopback with a stray start in cycle 10
    loop0 = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 10, 0);
    checkOutput("m2_rx", {16'd0, rx0}, 32'h00001234);
    checkOutput("m2_done_cnt", done_cnt, 1);
    checkOutput("m2_done_at", done_at, 67);

    // Reset in cycle 30 aborts the transfer
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFF, 0, 30);
    checkOutput("rst_cs", {30'd0, rst_cs}, 32'd3);
    checkOutput("rst_sck", {31'd0, rst_sck}, 32'd0);
    checkOutput("rst_busy", {31'd0, rst_busy}, 32'd0);
    checkOutput("rst_done_cnt", done_cnt, 0);
    checkOutput("rst_rx", {16'd0, rx0}, 32'd0);

    // 8-bit mode 1 against the slave model
    applyStimulus8(2'd0, 8'h96);
    checkOutput("w8_rx", {24'd0, rx1}, 32'h3C);
    checkOutput("w8_done_at", done_at, 18);
    checkOutput("w8_slave_rx", {24'd0, slave_rx}, 32'h96);
    checkOutput("w8_cs_bad", cs_bad, 0);

    // Out-of-range select: no CS, done still pulses
    applyStimulus8(2'd3, 8'h5A);
    checkOutput("nocs_cs_bad", cs_bad, 0);
    checkOutput("nocs_done_cnt", done_cnt, 1);
    checkOutput("nocs_done_at", done_at, 18);

`ifdef SPI_MASTER_LSB_FIRST_EN
    loop0 = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h0001, 0, 0);
    checkOutput("lsb_mosi_first", {31'd0, mosi_first}, 32'd1);
    checkOutput("lsb_mosi_high", mosi_high, 4);
    checkOutput("lsb_rx", {16'd0, rx0}, 32'h00000001);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
